draw_sequencer: RTL and testbench

Control FSM for the game's drawing datapath. It accepts one draw command at a time: a full-screen image, a 40x40 sprite at a selected slot, or a full-screen black clear. It sequences the coordinate registers, ROM address counters and colour select so that exactly one `plot` pulse is produced per pixel. It also converts round results into single-cycle point-register updates, independently of any draw in progress. It sits between the top-level game FSM and the datapath/VGA adapter.

---
 rtl/draw_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_draw_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// draw_sequencer
// Control FSM for the drawing datapath. Accepts one draw command at a time
// (full-screen image, 40x40 sprite at a slot, or full-screen black clear) and
// sequences the coordinate registers, ROM address counters and colour select
// so that exactly one plot pulse is produced per pixel. Independently of any
// draw, it turns round results into single-cycle point-register updates.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   start, kind       : draw request (kind 0 screen, 1 sprite, 2 black, 3 illegal)
//   memSelIn, xSelIn, ySelIn : ROM / slot selects, latched when a command starts
//   scoreValid, scoreP1, scoreP2, scoreClear : round result / point clear
//   x*/y* strobes, address counter strobes    : datapath control
//   xInitSel, yInitSel, memorySel, black, xySel : held for the whole command
//   playerReset, playerLoad, winner1, winner2 : registered point updates
//   plot, busy, done  : VGA write enable, command in progress, end pulse
//   debugState        : current FSM state
//
// Handshake: start is a request with no ready. It is honoured only while
// busy is low (IDLE); a start while busy is dropped, never queued. done pulses
// for one cycle and a new start is accepted in the very next cycle.
module draw_sequencer #(
  parameter int MEM_LATENCY = 2,
  parameter int SCR_W       = 160,
  parameter int SCR_H       = 120,
  parameter int SPR_W       = 40,
  parameter int SPR_H       = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] kind,
  input  logic [4:0] memSelIn,
  input  logic [3:0] xSelIn,
  input  logic [1:0] ySelIn,
  input  logic       scoreValid,
  input  logic       scoreP1,
  input  logic       scoreP2,
  input  logic       scoreClear,
  output logic       xInitReset,
  output logic       xInitLoad,
  output logic       yInitReset,
  output logic       yInitLoad,
  output logic       xCountUp,
  output logic       xReset,
  output logic       xLoad,
  output logic       xStart,
  output logic       yCountUp,
  output logic       yReset,
  output logic       yLoad,
  output logic       yStart,
  output logic       xySel,
  output logic       black,
  output logic       playerReset,
  output logic       winner1,
  output logic       winner2,
  output logic       playerLoad,
  output logic       addressScreenCounterReset,
  output logic       screenCountLoad,
  output logic       addressSpriteCounterReset,
  output logic       spriteCountLoad,
  output logic [3:0] xInitSel,
  output logic [1:0] yInitSel,
  output logic [4:0] memorySel,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic [2:0] debugState
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PRIME = 3'd2,
    WAIT  = 3'd3,
    PLOT  = 3'd4,
    DONE  = 3'd5
  } stateT;

  localparam int MAX_W = (SCR_W > SPR_W) ? SCR_W : SPR_W;
  localparam int MAX_H = (SCR_H > SPR_H) ? SCR_H : SPR_H;
  localparam int COL_W = $clog2(MAX_W + 1);
  localparam int ROW_W = $clog2(MAX_H + 1);
  localparam int LAT_W = $clog2(MEM_LATENCY + 1);

  stateT             state;
  stateT             nextState;
  logic [1:0]        kindQ;
  logic [4:0]        memSelQ;
  logic [3:0]        xSelQ;
  logic [1:0]        ySelQ;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [LAT_W-1:0]  waitCnt;

  logic              isSprite;
  logic              isBlack;
  logic              inCmd;
  logic              waitDone;
  logic              addrInc;
  logic [COL_W-1:0]  colLast;
  logic [ROW_W-1:0]  rowLast;

  assign isSprite = (kindQ == 2'd1);
  assign isBlack  = (kindQ == 2'd2);
  assign inCmd    = (state != IDLE);
  assign colLast  = isSprite ? COL_W'(SPR_W - 1) : COL_W'(SCR_W - 1);
  assign rowLast  = isSprite ? ROW_W'(SPR_H - 1) : ROW_W'(SCR_H - 1);
  // waitCnt is cleared on entry to WAIT, so the last wait cycle sees L-1.
  assign waitDone = (waitCnt == LAT_W'(MEM_LATENCY - 1));

  // Held outputs are gated by state so they read 0 in IDLE and drop
  // immediately on an asynchronous reset.
  assign busy       = inCmd;
  assign black      = inCmd & isBlack;
  assign xySel      = inCmd & isSprite;
  assign xInitSel   = inCmd ? xSelQ : 4'd0;
  assign yInitSel   = inCmd ? ySelQ : 2'd0;
  assign memorySel  = inCmd ? memSelQ : 5'd0;
  assign debugState = state;

  // State register plus the command's latched selects and pixel counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      kindQ   <= 2'd0;
      memSelQ <= 5'd0;
      xSelQ   <= 4'd0;
      ySelQ   <= 2'd0;
      col     <= '0;
      row     <= '0;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (start && kind != 2'd3) begin
            kindQ   <= kind;
            memSelQ <= memSelIn;
            xSelQ   <= xSelIn;
            ySelQ   <= ySelIn;
          end
        end
        SETUP: begin
          col <= '0;
          row <= '0;
        end
        PRIME: waitCnt <= '0;
        WAIT:  waitCnt <= waitCnt + LAT_W'(1);
        PLOT: begin
          waitCnt <= '0;
          if (col < colLast) begin
            col <= col + COL_W'(1);
          end else if (row < rowLast) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and per-state datapath strobes.
  always_comb begin
    nextState                 = state;
    xInitReset                = 1'b0;
    xInitLoad                 = 1'b0;
    yInitReset                = 1'b0;
    yInitLoad                 = 1'b0;
    xCountUp                  = 1'b0;
    xReset                    = 1'b0;
    xLoad                     = 1'b0;
    xStart                    = 1'b0;
    yCountUp                  = 1'b0;
    yReset                    = 1'b0;
    yLoad                     = 1'b0;
    yStart                    = 1'b0;
    addressScreenCounterReset = 1'b0;
    addressSpriteCounterReset = 1'b0;
    addrInc                   = 1'b0;
    plot                      = 1'b0;
    done                      = 1'b0;
    case (state)
      IDLE: begin
        if (start && kind != 2'd3) nextState = SETUP;
      end
      SETUP: begin
        xInitLoad = 1'b1;
        yInitLoad = 1'b1;
        if (isSprite) begin
          addressSpriteCounterReset = 1'b1;
        end else begin
          xInitReset                = 1'b1;
          yInitReset                = 1'b1;
          addressScreenCounterReset = 1'b1;
        end
        nextState = PRIME;
      end
      PRIME: begin
        xLoad     = 1'b1;
        xStart    = 1'b1;
        yLoad     = 1'b1;
        yStart    = 1'b1;
        nextState = WAIT;
      end
      WAIT: begin
        if (waitDone) nextState = PLOT;
      end
      PLOT: begin
        plot = 1'b1;
        if (col < colLast) begin
          xCountUp  = 1'b1;
          addrInc   = 1'b1;
          nextState = WAIT;
        end else if (row < rowLast) begin
          // End of a line: reload x from its init value, step y.
          xLoad     = 1'b1;
          xStart    = 1'b1;
          yCountUp  = 1'b1;
          addrInc   = 1'b1;
          nextState = WAIT;
        end else begin
          nextState = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Screen and black commands walk the screen ROM counter, sprites their own.
  assign screenCountLoad = addrInc & ~isSprite;
  assign spriteCountLoad = addrInc & isSprite;

  // Score path: one-cycle registered pulses, independent of the draw FSM.
  // A clear wins over a simultaneous result; a result with zero or two
  // winners is meaningless and dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      playerReset <= 1'b0;
      playerLoad  <= 1'b0;
      winner1     <= 1'b0;
      winner2     <= 1'b0;
    end else begin
      playerReset <= scoreClear;
      playerLoad  <= ~scoreClear & scoreValid & (scoreP1 ^ scoreP2);
      winner1     <= ~scoreClear & scoreValid & scoreP1 & ~scoreP2;
      winner2     <= ~scoreClear & scoreValid & scoreP2 & ~scoreP1;
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer
// Self-checking bench for draw_sequencer. A cycle-offset model predicts every
// output from the command's start cycle with plain arithmetic; the main
// process compares the full output vector each cycle and adds literal checks
// for pulse counts, done timing and the score path.
module tb_draw_sequencer;

  localparam int L     = 2;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int SPR_W = 40;
  localparam int SPR_H = 40;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [1:0] kind = 2'd0;
  logic [4:0] memSelIn = 5'd0;
  logic [3:0] xSelIn = 4'd0;
  logic [1:0] ySelIn = 2'd0;
  logic       scoreValid = 1'b0;
  logic       scoreP1 = 1'b0;
  logic       scoreP2 = 1'b0;
  logic       scoreClear = 1'b0;

  logic xInitReset, xInitLoad, yInitReset, yInitLoad, xCountUp, xReset;
  logic xLoad, xStart, yCountUp, yReset, yLoad, yStart, xySel, black;
  logic playerReset, winner1, winner2, playerLoad;
  logic addressScreenCounterReset, screenCountLoad;
  logic addressSpriteCounterReset, spriteCountLoad;
  logic [3:0] xInitSel;
  logic [1:0] yInitSel;
  logic [4:0] memorySel;
  logic plot, busy, done;
  logic [2:0] debugState;

  draw_sequencer #(
    .MEM_LATENCY(L), .SCR_W(SCR_W), .SCR_H(SCR_H), .SPR_W(SPR_W), .SPR_H(SPR_H)
  ) dut (
    .clk(clk), .reset(rst), .start(start), .kind(kind),
    .memSelIn(memSelIn), .xSelIn(xSelIn), .ySelIn(ySelIn),
    .scoreValid(scoreValid), .scoreP1(scoreP1), .scoreP2(scoreP2),
    .scoreClear(scoreClear),
    .xInitReset(xInitReset), .xInitLoad(xInitLoad),
    .yInitReset(yInitReset), .yInitLoad(yInitLoad),
    .xCountUp(xCountUp), .xReset(xReset), .xLoad(xLoad), .xStart(xStart),
    .yCountUp(yCountUp), .yReset(yReset), .yLoad(yLoad), .yStart(yStart),
    .xySel(xySel), .black(black),
    .playerReset(playerReset), .winner1(winner1), .winner2(winner2),
    .playerLoad(playerLoad),
    .addressScreenCounterReset(addressScreenCounterReset),
    .screenCountLoad(screenCountLoad),
    .addressSpriteCounterReset(addressSpriteCounterReset),
    .spriteCountLoad(spriteCountLoad),
    .xInitSel(xInitSel), .yInitSel(yInitSel), .memorySel(memorySel),
    .plot(plot), .busy(busy), .done(done), .debugState(debugState)
  );

  logic [35:0] dutVec;
  assign dutVec = {xInitReset, xInitLoad, yInitReset, yInitLoad, xCountUp, xReset,
                   xLoad, xStart, yCountUp, yReset, yLoad, yStart, xySel, black,
                   playerReset, winner1, winner2, playerLoad,
                   addressScreenCounterReset, screenCountLoad,
                   addressSpriteCounterReset, spriteCountLoad,
                   xInitSel, yInitSel, memorySel, plot, busy, done};

  // ---------------- reference model ----------------
  // mOffs is the cycle index within the current command (1 = first cycle
  // after the accepted start), or -1 when no command is running.
  int         mOffs = -1;
  logic [1:0] mKind = 2'd0;
  logic [4:0] mMem = 5'd0;
  logic [3:0] mX = 4'd0;
  logic [1:0] mY = 2'd0;
  logic       eRst = 1'b0, eLd = 1'b0, eW1 = 1'b0, eW2 = 1'b0;

  function automatic int cmdLen(input logic [1:0] k);
    int p;
    p = (k == 2'd1) ? SPR_W * SPR_H : SCR_W * SCR_H;
    return 3 + p * (L + 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mOffs = -1;
      eRst = 1'b0; eLd = 1'b0; eW1 = 1'b0; eW2 = 1'b0;
    end else begin
      if (mOffs < 0) begin
        if (start && kind != 2'd3) begin
          mOffs = 1; mKind = kind; mMem = memSelIn; mX = xSelIn; mY = ySelIn;
        end
      end else if (mOffs == cmdLen(mKind)) begin
        mOffs = -1;
      end else begin
        mOffs++;
      end
      eRst = scoreClear;
      eLd  = !scoreClear && scoreValid && (scoreP1 != scoreP2);
      eW1  = eLd && scoreP1;
      eW2  = eLd && scoreP2;
    end
  end

  function automatic logic [35:0] expVector();
    logic xIR, xIL, yIR, yIL, xCU, xLd, xSt, yCU, yLd, ySt, xyS, blk;
    logic aScR, aSpR, inc, pl, bz, dn, spr;
    logic [3:0] xs;
    logic [1:0] ys;
    logic [4:0] ms;
    int w, h, j, p, c, r;
    {xIR, xIL, yIR, yIL, xCU, xLd, xSt, yCU, yLd, ySt, xyS, blk} = '0;
    {aScR, aSpR, inc, pl, bz, dn, spr} = '0;
    xs = '0; ys = '0; ms = '0;
    if (rst) return '0;
    if (mOffs > 0) begin
      spr = (mKind == 2'd1);
      w = spr ? SPR_W : SCR_W;
      h = spr ? SPR_H : SCR_H;
      bz = 1'b1; xs = mX; ys = mY; ms = mMem;
      blk = (mKind == 2'd2); xyS = spr;
      if (mOffs == 1) begin
        xIL = 1'b1; yIL = 1'b1;
        if (spr) aSpR = 1'b1;
        else begin xIR = 1'b1; yIR = 1'b1; aScR = 1'b1; end
      end else if (mOffs == 2) begin
        xLd = 1'b1; xSt = 1'b1; yLd = 1'b1; ySt = 1'b1;
      end else if (mOffs == cmdLen(mKind)) begin
        dn = 1'b1;
      end else begin
        j = mOffs - 3;
        if (j % (L + 1) == L) begin
          pl = 1'b1;
          p = j / (L + 1);
          c = p % w;
          r = p / w;
          if (c < w - 1) begin xCU = 1'b1; inc = 1'b1; end
          else if (r < h - 1) begin xLd = 1'b1; xSt = 1'b1; yCU = 1'b1; inc = 1'b1; end
        end
      end
    end
    return {xIR, xIL, yIR, yIL, xCU, 1'b0, xLd, xSt, yCU, 1'b0, yLd, ySt, xyS, blk,
            eRst, eW1, eW2, eLd, aScR, inc & ~spr, aSpR, inc & spr,
            xs, ys, ms, pl, bz, dn};
  endfunction

  // ---------------- scoreboard ----------------
  int nChecks = 0;
  int nFails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic atNeg();
    @(negedge clk);
    chk("outputs", {28'd0, dutVec}, {28'd0, expVector()});
  endtask

  task automatic toNext();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      atNeg();
      toNext();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic scorePulse(input logic clr, input logic v, input logic p1, input logic p2,
                            input logic [3:0] exp, input string name);
    scoreClear = clr; scoreValid = v; scoreP1 = p1; scoreP2 = p2;
    atNeg();
    toNext();
    scoreClear = 1'b0; scoreValid = 1'b0; scoreP1 = 1'b0; scoreP2 = 1'b0;
    atNeg();
    chk(name, {60'd0, playerReset, playerLoad, winner1, winner2}, {60'd0, exp});
    toNext();
  endtask

  // Issues one command and follows it to done (or to an abort cycle).
  // Returns with the bench at the negedge of the last observed cycle.
  task automatic runCmd(input logic [1:0] k, input logic [4:0] m, input logic [3:0] x,
                        input logic [1:0] y, input int pokeAt, input int abortAt,
                        input bit randScore, input bit dirScore,
                        output int doneAt, output int plots, output int yUps,
                        output int sprInc, output int scrInc, output int badHeld);
    int n;
    doneAt = -1; plots = 0; yUps = 0; sprInc = 0; scrInc = 0; badHeld = 0;
    start = 1'b1; kind = k; memSelIn = m; xSelIn = x; ySelIn = y;
    atNeg();
    toNext();
    start = 1'b0;
    n = 1;
    while (n <= 60000) begin
      if (n == abortAt) begin
        rst = 1'b1;
        #1;
        chk("abort_plot", {63'd0, plot}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
      end
      atNeg();
      if (plot) plots++;
      if (yCountUp) yUps++;
      if (spriteCountLoad) sprInc++;
      if (screenCountLoad) scrInc++;
      if (busy && (xInitSel != x || yInitSel != y || memorySel != m ||
                   black != (k == 2'd2) || xySel != (k == 2'd1))) badHeld++;
      if (dirScore && n == 51)
        chk("draw_score_p2", {61'd0, playerLoad, winner1, winner2}, 64'b101);
      if (done) begin
        doneAt = n;
        break;
      end
      if (n == abortAt) break;
      toNext();
      n++;
      start = (n == pokeAt);
      kind = start ? 2'd1 : 2'($urandom_range(0, 3));
      memSelIn = 5'($urandom);
      xSelIn = 4'($urandom);
      ySelIn = 2'($urandom);
      if (randScore) begin
        scoreClear = ($urandom_range(0, 15) == 0);
        scoreValid = 1'($urandom_range(0, 1));
        scoreP1 = 1'($urandom_range(0, 1));
        scoreP2 = 1'($urandom_range(0, 1));
      end else begin
        scoreClear = 1'b0; scoreValid = 1'b0; scoreP1 = 1'b0; scoreP2 = 1'b0;
      end
      if (dirScore && n == 50) begin
        scoreValid = 1'b1; scoreP1 = 1'b0; scoreP2 = 1'b1;
      end
    end
    start = 1'b0; kind = 2'd0;
    scoreClear = 1'b0; scoreValid = 1'b0; scoreP1 = 1'b0; scoreP2 = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dAt, pl, yu, si, sc, bh;

    // Model pins: hand-computed command lengths.
    chk("len_sprite", 64'(cmdLen(2'd1)), 64'd4803);
    chk("len_screen", 64'(cmdLen(2'd0)), 64'd57603);

    idle(3);
    atNeg();
    chk("reset_vec", {28'd0, dutVec}, 64'd0);
    toNext();
    rst = 1'b0;
    idle(2);

    // Score path in IDLE.
    scorePulse(1'b0, 1'b1, 1'b0, 1'b1, 4'b0101, "score_p2");
    scorePulse(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, "score_both");
    scorePulse(1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, "score_clear_prio");
    scorePulse(1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, "score_p1");
    scorePulse(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, "score_none");

    // Sprite, directed score during the draw.
    runCmd(2'd1, 5'd12, 4'd3, 2'd1, 0, 0, 1'b0, 1'b1, dAt, pl, yu, si, sc, bh);
    chk("spr_done_at", 64'(dAt), 64'd4803);
    chk("spr_plots", 64'(pl), 64'd1600);
    chk("spr_ycount", 64'(yu), 64'd39);
    chk("spr_addr_inc", 64'(si), 64'd1599);
    chk("spr_scr_inc", 64'(sc), 64'd0);
    chk("spr_held", 64'(bh), 64'd0);
    toNext();

    // Back-to-back sprite with random selects, a start poke at cycle 100
    // and random score traffic.
    runCmd(2'd1, 5'($urandom), 4'($urandom), 2'($urandom), 100, 0, 1'b1, 1'b0,
           dAt, pl, yu, si, sc, bh);
    chk("poke_done_at", 64'(dAt), 64'd4803);
    chk("poke_plots", 64'(pl), 64'd1600);
    chk("poke_held", 64'(bh), 64'd0);
    toNext();

    // Illegal kind in IDLE is ignored.
    start = 1'b1; kind = 2'd3;
    atNeg();
    toNext();
    start = 1'b0; kind = 2'd0;
    for (int i = 0; i < 4; i++) begin
      atNeg();
      chk("illegal_busy", {63'd0, busy}, 64'd0);
      toNext();
    end

    // Black clear.
    runCmd(2'd2, 5'd0, 4'd0, 2'd0, 0, 0, 1'b1, 1'b0, dAt, pl, yu, si, sc, bh);
    chk("blk_done_at", 64'(dAt), 64'd57603);
    chk("blk_plots", 64'(pl), 64'd19200);
    chk("blk_ycount", 64'(yu), 64'd119);
    chk("blk_spr_inc", 64'(si), 64'd0);
    chk("blk_scr_inc", 64'(sc), 64'd19199);
    chk("blk_held", 64'(bh), 64'd0);
    toNext();

    // Screen draw aborted by reset at cycle 2000.
    runCmd(2'd0, 5'd5, 4'd2, 2'd3, 0, 2000, 1'b1, 1'b0, dAt, pl, yu, si, sc, bh);
    chk("abort_no_done", 64'(dAt), 64'hFFFF_FFFF_FFFF_FFFF);
    toNext();
    rst = 1'b0;
    idle(2);
    atNeg();
    chk("post_abort_idle", {63'd0, busy}, 64'd0);
    toNext();

    runCmd(2'd1, 5'd7, 4'd9, 2'd2, 0, 0, 1'b1, 1'b0, dAt, pl, yu, si, sc, bh);
    chk("rerun_done_at", 64'(dAt), 64'd4803);
    chk("rerun_plots", 64'(pl), 64'd1600);
    toNext();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
